// File: rtl/item_memory_sequencer.sv
// item_memory_sequencer: round-robin burst lookup controller in front of
// item_memory. Grants one requester at a time, streams one lookup per cycle
// through memory ports A (auto-incrementing) and B (fixed), and returns the
// hypervector pairs through a registered valid/ready output stage.
module item_memory_sequencer #(
  parameter int HVDimension = 512,
  parameter int NumTotIm    = 1024,
  parameter int NumReq      = 2,
  parameter int LenWidth    = 8,
  parameter int ImAddrWidth = $clog2(NumTotIm),
  parameter int IdWidth     = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [NumReq-1:0]               req_valid_i,
  output logic [NumReq-1:0]               req_ready_o,
  input  logic [NumReq-1:0]               req_cim_i,
  input  logic [NumReq*ImAddrWidth-1:0]   req_addr_a_i,
  input  logic [NumReq*ImAddrWidth-1:0]   req_addr_b_i,
  input  logic [NumReq*LenWidth-1:0]      req_len_i,
  output logic                            im_port_a_cim_o,
  output logic [ImAddrWidth-1:0]          im_a_addr_o,
  output logic [ImAddrWidth-1:0]          im_b_addr_o,
  input  logic [HVDimension-1:0]          im_a_i,
  input  logic [HVDimension-1:0]          im_b_i,
  output logic                            out_valid_o,
  input  logic                            out_ready_i,
  output logic [HVDimension-1:0]          out_a_o,
  output logic [HVDimension-1:0]          out_b_o,
  output logic [IdWidth-1:0]              out_id_o,
  output logic                            out_last_o,
  output logic                            busy_o
);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t                 state_q;
  logic [IdWidth-1:0]     rr_q;
  logic                   cim_q;
  logic [ImAddrWidth-1:0] addr_a_q;
  logic [ImAddrWidth-1:0] addr_b_q;
  logic [LenWidth-1:0]    cnt_q;
  logic [IdWidth-1:0]     id_q;

  logic                   out_valid_q;
  logic [HVDimension-1:0] out_a_q;
  logic [HVDimension-1:0] out_b_q;
  logic [IdWidth-1:0]     out_id_q;
  logic                   out_last_q;

  logic                   pick_found;
  logic [IdWidth-1:0]     pick_id;
  logic [IdWidth-1:0]     next_rr;
  logic [NumReq-1:0]      ready_vec;
  logic                   accept;
  logic                   capture;

  // Index of the requester at position off counted from base, wrapping at NumReq.
  function automatic logic [IdWidth-1:0] rot_idx(input logic [IdWidth-1:0] base,
                                                input int off);
    int s;
    s = int'(base) + off;
    if (s >= NumReq) s = s - NumReq;
    return IdWidth'(s);
  endfunction

  // Round-robin pick: first valid requester starting at the pointer.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    for (int i = 0; i < NumReq; i++) begin
      if (!pick_found && req_valid_i[rot_idx(rr_q, i)]) begin
        pick_found = 1'b1;
        pick_id    = rot_idx(rr_q, i);
      end
    end
  end

  // One-hot ready on the pick, only while idle and out of reset.
  always_comb begin
    ready_vec = '0;
    if (state_q == IDLE && rst_ni && pick_found) ready_vec[pick_id] = 1'b1;
  end

  assign next_rr = (pick_id == IdWidth'(NumReq - 1)) ? '0 : pick_id + 1'b1;
  assign accept  = (state_q == IDLE) && pick_found;
  // A lookup is captured whenever the output slot is free or being drained.
  assign capture = (state_q == STREAM) && (!out_valid_q || out_ready_i);

  // Command FSM: latch the granted command, then walk port A one step per capture.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      rr_q     <= '0;
      cim_q    <= 1'b0;
      addr_a_q <= '0;
      addr_b_q <= '0;
      cnt_q    <= '0;
      id_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            cim_q    <= req_cim_i[pick_id];
            addr_a_q <= req_addr_a_i[int'(pick_id)*ImAddrWidth +: ImAddrWidth];
            addr_b_q <= req_addr_b_i[int'(pick_id)*ImAddrWidth +: ImAddrWidth];
            cnt_q    <= req_len_i[int'(pick_id)*LenWidth +: LenWidth];
            id_q     <= pick_id;
            rr_q     <= next_rr;
            state_q  <= STREAM;
          end
        end
        STREAM: begin
          if (capture) begin
            // Address width equals log2(NumTotIm), so the increment wraps naturally.
            addr_a_q <= addr_a_q + 1'b1;
            if (cnt_q == '0) begin
              state_q <= IDLE;
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Output register: load on capture, hold under backpressure, drop after a bare handshake.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid_q <= 1'b0;
      out_a_q     <= '0;
      out_b_q     <= '0;
      out_id_q    <= '0;
      out_last_q  <= 1'b0;
    end else if (capture) begin
      out_valid_q <= 1'b1;
      out_a_q     <= im_a_i;
      out_b_q     <= im_b_i;
      out_id_q    <= id_q;
      out_last_q  <= (cnt_q == '0);
    end else if (out_ready_i) begin
      out_valid_q <= 1'b0;
    end
  end

  assign req_ready_o     = ready_vec;
  assign im_port_a_cim_o = (state_q == STREAM) ? cim_q    : 1'b0;
  assign im_a_addr_o     = (state_q == STREAM) ? addr_a_q : '0;
  assign im_b_addr_o     = (state_q == STREAM) ? addr_b_q : '0;
  assign out_valid_o     = out_valid_q;
  assign out_a_o         = out_a_q;
  assign out_b_o         = out_b_q;
  assign out_id_o        = out_id_q;
  assign out_last_o      = out_last_q;
  assign busy_o          = (state_q == STREAM) || out_valid_q;

endmodule

// File: tb/tb_item_memory_sequencer.sv
// Testbench for item_memory_sequencer: table-driven bursts, hand-written
// corner sequences and random traffic against a queue-based reference model.
module tb_item_memory_sequencer;

  localparam int HV = 512;
  localparam int NT = 1024;
  localparam int NR = 2;
  localparam int LW = 8;
  localparam int AW = 10;
  localparam int IW = 1;

  logic               clk = 1'b0;
  logic               rst_ni;
  logic [NR-1:0]      req_valid_i;
  logic [NR-1:0]      req_ready_o;
  logic [NR-1:0]      req_cim_i;
  logic [NR*AW-1:0]   req_addr_a_i;
  logic [NR*AW-1:0]   req_addr_b_i;
  logic [NR*LW-1:0]   req_len_i;
  logic               im_port_a_cim_o;
  logic [AW-1:0]      im_a_addr_o;
  logic [AW-1:0]      im_b_addr_o;
  logic [HV-1:0]      im_a_i;
  logic [HV-1:0]      im_b_i;
  logic               out_valid_o;
  logic               out_ready_i;
  logic [HV-1:0]      out_a_o;
  logic [HV-1:0]      out_b_o;
  logic [IW-1:0]      out_id_o;
  logic               out_last_o;
  logic               busy_o;

  item_memory_sequencer #(
    .HVDimension(HV), .NumTotIm(NT), .NumReq(NR), .LenWidth(LW)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_cim_i(req_cim_i),
    .req_addr_a_i(req_addr_a_i), .req_addr_b_i(req_addr_b_i), .req_len_i(req_len_i),
    .im_port_a_cim_o(im_port_a_cim_o), .im_a_addr_o(im_a_addr_o), .im_b_addr_o(im_b_addr_o),
    .im_a_i(im_a_i), .im_b_i(im_b_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_a_o(out_a_o), .out_b_o(out_b_o), .out_id_o(out_id_o),
    .out_last_o(out_last_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  // Distinct, address-tagged hypervector content for the memory model.
  function automatic logic [HV-1:0] hv(input logic [7:0] tag, input int addr);
    logic [31:0] w;
    w = {tag, 8'h3C, 6'd0, addr[9:0]};
    return {16{w}};
  endfunction

  // Item memory model: CiM levels use only the low 8 address bits (HV/2 = 256).
  assign im_a_i = im_port_a_cim_o ? hv(8'hC1, int'(im_a_addr_o) % 256)
                                  : hv(8'hA5, int'(im_a_addr_o));
  assign im_b_i = hv(8'hB7, int'(im_b_addr_o));

  typedef struct {
    logic [HV-1:0] a;
    logic [HV-1:0] b;
    int            id;
    logic          last;
  } item_t;

  typedef struct {
    int   req;
    logic cim;
    int   addr_a;
    int   addr_b;
    int   len;
    int   exp_first;
    int   exp_last;
  } vec_t;

  item_t         exp_q[$];
  int            tests = 0;
  int            fails = 0;
  int            cyc = 0;
  int            last_grant;
  int            grant_cnt, grant_id, grant_cyc;
  int            n_hs, first_hs_cyc, last_hs_cyc;
  logic [HV-1:0] first_a, last_a, last_b;
  logic [NR-1:0] granted_mask;
  logic          prev_hold;
  logic [HV-1:0] h_a, h_b;
  logic [IW-1:0] h_id;
  logic          h_last;

  task automatic check(input string name, input logic [HV-1:0] act, input logic [HV-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_cmd(input int r, input logic cim, input int a, input int b, input int len);
    req_cim_i[r]             = cim;
    req_addr_a_i[r*AW +: AW] = AW'(a);
    req_addr_b_i[r*AW +: AW] = AW'(b);
    req_len_i[r*LW +: LW]    = LW'(len);
  endtask

  // Reference model and protocol checks, evaluated mid-cycle.
  task automatic monitor();
    item_t         e;
    int            pick, a0, ln, ea;
    logic [HV-1:0] onehot;
    if (!rst_ni) return;
    if (prev_hold) begin
      check("hold_valid", HV'(out_valid_o), HV'(1));
      check("hold_a", out_a_o, h_a);
      check("hold_b", out_b_o, h_b);
      check("hold_id_last", HV'({out_id_o, out_last_o}), HV'({h_id, h_last}));
    end
    prev_hold = out_valid_o && !out_ready_i;
    h_a = out_a_o; h_b = out_b_o; h_id = out_id_o; h_last = out_last_o;
    if (out_valid_o) check("busy_with_valid", HV'(busy_o), HV'(1));
    if (!busy_o) check("idle_drive", HV'({im_port_a_cim_o, im_a_addr_o, im_b_addr_o}), HV'(0));
    if (req_ready_o != '0) begin
      pick = -1;
      for (int k = 1; k <= NR; k++)
        if (pick < 0 && req_valid_i[(last_grant + k) % NR]) pick = (last_grant + k) % NR;
      onehot = '0;
      if (pick >= 0) onehot[pick] = 1'b1;
      check("grant", HV'(req_ready_o), onehot);
      if (pick >= 0) begin
        a0 = int'(req_addr_a_i[pick*AW +: AW]);
        ln = int'(req_len_i[pick*LW +: LW]);
        for (int k = 0; k <= ln; k++) begin
          ea     = (a0 + k) % NT;
          e.a    = req_cim_i[pick] ? hv(8'hC1, ea % 256) : hv(8'hA5, ea);
          e.b    = hv(8'hB7, int'(req_addr_b_i[pick*AW +: AW]));
          e.id   = pick;
          e.last = (k == ln);
          exp_q.push_back(e);
        end
        last_grant = pick;
        grant_id   = pick;
        grant_cyc  = cyc;
        grant_cnt++;
        granted_mask[pick] = 1'b1;
      end
    end
    if (out_valid_o && out_ready_i) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out", HV'(out_valid_o), HV'(0));
      end else begin
        e = exp_q.pop_front();
        check("out_a", out_a_o, e.a);
        check("out_b", out_b_o, e.b);
        check("out_id", HV'(out_id_o), HV'(e.id));
        check("out_last", HV'(out_last_o), HV'(e.last));
      end
      if (n_hs == 0) begin
        first_hs_cyc = cyc;
        first_a      = out_a_o;
      end
      last_hs_cyc = cyc;
      last_a      = out_a_o;
      last_b      = out_b_o;
      n_hs++;
    end
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic wait_grant(input int bound);
    for (int w = 0; w < bound && grant_cnt == 0; w++) step();
    check("grant_timeout", HV'(grant_cnt > 0), HV'(1));
  endtask

  task automatic wait_hs(input int n, input int bound);
    for (int w = 0; w < bound && n_hs < n; w++) step();
    check("handshake_timeout", HV'(n_hs), HV'(n));
  endtask

  task automatic drain(input int bound);
    out_ready_i = 1'b1;
    for (int w = 0; w < bound; w++) begin
      if (exp_q.size() == 0 && !busy_o) break;
      step();
    end
    check("drain", HV'({exp_q.size() != 0, busy_o}), HV'(0));
  endtask

  task automatic model_reset();
    exp_q.delete();
    last_grant   = NR - 1;
    prev_hold    = 1'b0;
    granted_mask = '0;
  endtask

  vec_t vecs[3];
  int   seq[4];
  int   prev_cnt;

  initial begin
    vecs[0] = '{req: 0, cim: 1'b0, addr_a: 5,    addr_b: 9,  len: 3, exp_first: 5,    exp_last: 8};
    vecs[1] = '{req: 0, cim: 1'b0, addr_a: 1022, addr_b: 3,  len: 3, exp_first: 1022, exp_last: 1};
    vecs[2] = '{req: 1, cim: 1'b1, addr_a: 254,  addr_b: 17, len: 2, exp_first: 254,  exp_last: 0};

    req_valid_i = '0; req_cim_i = '0; req_addr_a_i = '0; req_addr_b_i = '0; req_len_i = '0;
    out_ready_i = 1'b0;
    model_reset();
    grant_cnt = 0; n_hs = 0;

    // Reset state, with a requester valid to show ready is suppressed.
    rst_ni = 1'b0;
    set_cmd(0, 1'b0, 1, 2, 0);
    req_valid_i = 2'b01;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", HV'(req_ready_o), HV'(0));
    check("rst_valid_busy", HV'({out_valid_o, busy_o, out_last_o, out_id_o}), HV'(0));
    check("rst_out_a", out_a_o, '0);
    check("rst_out_b", out_b_o, '0);
    check("rst_im_drive", HV'({im_port_a_cim_o, im_a_addr_o, im_b_addr_o}), HV'(0));
    req_valid_i = '0;
    rst_ni = 1'b1;
    step();

    // Arbitration: both requesters continuously valid, single-lookup bursts.
    set_cmd(0, 1'b0, 10, 20, 0);
    set_cmd(1, 1'b0, 30, 40, 0);
    req_valid_i = 2'b11;
    out_ready_i = 1'b1;
    for (int w = 0; w < 40 && grant_cnt < 4; w++) begin
      prev_cnt = grant_cnt;
      step();
      if (grant_cnt > prev_cnt) seq[grant_cnt-1] = grant_id;
    end
    check("arb_count", HV'(grant_cnt), HV'(4));
    for (int k = 0; k < 4; k++) check("arb_order", HV'(seq[k]), HV'(k % 2));
    req_valid_i = '0;
    drain(20);

    // Table-driven bursts with full-rate output.
    for (int t = 0; t < 3; t++) begin
      set_cmd(vecs[t].req, vecs[t].cim, vecs[t].addr_a, vecs[t].addr_b, vecs[t].len);
      grant_cnt = 0; n_hs = 0;
      out_ready_i = 1'b1;
      req_valid_i = '0;
      req_valid_i[vecs[t].req] = 1'b1;
      wait_grant(10);
      req_valid_i = '0;
      check("vec_grant_id", HV'(grant_id), HV'(vecs[t].req));
      wait_hs(vecs[t].len + 1, 20);
      check("vec_first_cycle", HV'(first_hs_cyc), HV'(grant_cyc + 2));
      check("vec_last_cycle", HV'(last_hs_cyc), HV'(grant_cyc + vecs[t].len + 2));
      check("vec_first_a", first_a,
            vecs[t].cim ? hv(8'hC1, vecs[t].exp_first) : hv(8'hA5, vecs[t].exp_first));
      check("vec_last_a", last_a,
            vecs[t].cim ? hv(8'hC1, vecs[t].exp_last) : hv(8'hA5, vecs[t].exp_last));
      check("vec_b", last_b, hv(8'hB7, vecs[t].addr_b));
      drain(10);
    end

    // Backpressure: output stalled for three cycles after the first valid.
    set_cmd(0, 1'b0, 5, 9, 2);
    grant_cnt = 0; n_hs = 0;
    out_ready_i = 1'b0;
    req_valid_i = 2'b01;
    wait_grant(10);
    req_valid_i = '0;
    step();
    for (int k = 0; k < 3; k++) begin
      check("bp_valid", HV'(out_valid_o), HV'(1));
      check("bp_addr_frozen", HV'(im_a_addr_o), HV'(6));
      check("bp_out_a", out_a_o, hv(8'hA5, 5));
      step();
    end
    out_ready_i = 1'b1;
    wait_hs(3, 20);
    drain(10);
    check("bp_queue_empty", HV'(exp_q.size()), HV'(0));

    // Asynchronous reset mid-burst, then a fresh command from requester 1.
    set_cmd(0, 1'b0, 100, 7, 4);
    grant_cnt = 0; n_hs = 0;
    out_ready_i = 1'b1;
    req_valid_i = 2'b01;
    wait_grant(10);
    req_valid_i = '0;
    wait_hs(2, 10);
    rst_ni = 1'b0;
    req_valid_i = 2'b11;
    #1;
    check("arst_valid", HV'(out_valid_o), HV'(0));
    check("arst_busy", HV'(busy_o), HV'(0));
    check("arst_ready", HV'(req_ready_o), HV'(0));
    req_valid_i = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_ni = 1'b1;
    set_cmd(1, 1'b0, 300, 12, 1);
    grant_cnt = 0; n_hs = 0;
    req_valid_i = 2'b10;
    step();
    check("post_rst_grant", HV'({grant_cnt, grant_id}), HV'({32'd1, 32'd1}));
    req_valid_i = '0;
    wait_hs(2, 10);
    check("post_rst_last_a", last_a, hv(8'hA5, 301));
    drain(10);

    // Random traffic with random backpressure.
    for (int c = 0; c < 1500; c++) begin
      for (int r = 0; r < NR; r++) begin
        if (!req_valid_i[r] && $urandom_range(0, 3) == 0) begin
          set_cmd(r, 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) == 0) ? 1020 + int'($urandom_range(0, 3))
                                              : int'($urandom_range(0, NT - 1)),
                  int'($urandom_range(0, NT - 1)), int'($urandom_range(0, 5)));
          req_valid_i[r] = 1'b1;
        end
      end
      out_ready_i = ($urandom_range(0, 9) < 7);
      granted_mask = '0;
      step();
      req_valid_i = req_valid_i & ~granted_mask;
    end
    req_valid_i = '0;
    drain(300);
    check("final_queue_empty", HV'(exp_q.size()), HV'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
